lc3_mem_resp: RTL and testbench

//  Memory/IO responder on the LC-3 core's memory bus: serves MIO_EN/R_W requests from the control FSM.

---
 rtl/lc3_mem_resp.sv | 222 ++++++++++++++++++++++
 tb/tb_lc3_mem_resp.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_resp.sv
// lc3_mem_resp: LC-3 memory/IO responder.
// Serves MIO_EN/R_W requests from the core. Addresses below IO_BASE go to an
// external synchronous SRAM (MEM_LAT wait cycles); addresses from IO_BASE up
// hit the device-register page (KBSR/KBDR/DSR/DDR/MCR) in the accept cycle.
// Handshake: mio_en is a level held by the requester; it is sampled only in
// IDLE, and ready is a one-cycle pulse in RESP that ends the transaction.
// Optional feature: define LC3_KB_IRQ_EN to make KBSR[14] writable and add the
// registered kb_irq output.
module lc3_mem_resp #(
  parameter int          MEM_LAT = 2,
  parameter logic [15:0] USR_LO  = 16'h3000,
  parameter logic [15:0] IO_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  input  logic        psr_15,
  output logic [15:0] mem_rdata,
  output logic        ready,
  output logic        acv,
  output logic        sram_cs,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        halt,
`ifdef LC3_KB_IRQ_EN
  output logic        kb_irq,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;
  localparam logic [15:0] MCR_A  = 16'hFFFE;
  localparam logic [3:0]  LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SRAM = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        kbsr15_q, kbsr15_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        dsp_valid_q, dsp_valid_d;
  logic [7:0]  dsp_data_q, dsp_data_d;
  logic [15:0] mcr_q, mcr_d;
  logic        kb_ie;
  logic [15:0] reg_val;
  logic        kbdr_clr;
  logic        dsp_load;

`ifdef LC3_KB_IRQ_EN
  logic kbie_q, kbie_d;
  logic kb_irq_q, kb_irq_d;
  assign kb_ie  = kbie_q;
  assign kb_irq = kb_irq_q;
`else
  assign kb_ie = 1'b0;
`endif

  // Access violation is purely address/mode based and never blocks the access.
  assign acv = psr_15 & ((mar < USR_LO) | (mar >= IO_BASE));

  assign sram_addr  = mar_q;
  assign sram_wdata = wdata_q;
  assign kb_ready   = ~kbsr15_q;
  assign dsp_valid  = dsp_valid_q;
  assign dsp_data   = dsp_data_q;
  assign halt       = ~mcr_q[15];
  assign dbg_state  = state_q;

  // SRAM read data is forwarded straight through in the ready cycle; otherwise the held value.
  assign mem_rdata = (state_q == RESP && !rw_q && mar_q < IO_BASE) ? sram_rdata : rdata_q;

  // Device-register read mux, indexed by the live address in the accept cycle.
  always_comb begin
    reg_val = 16'h0000;
    case (mar)
      KBSR_A:  reg_val = {kbsr15_q, kb_ie, 14'h0};
      KBDR_A:  reg_val = {8'h00, kbdr_q};
      DSR_A:   reg_val = {~dsp_valid_q, 15'h0};
      MCR_A:   reg_val = mcr_q;
      default: reg_val = 16'h0000;
    endcase
  end

  // Next-state, bus outputs and device-register updates.
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    mar_d       = mar_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    kbsr15_d    = kbsr15_q;
    kbdr_d      = kbdr_q;
    dsp_valid_d = dsp_valid_q;
    dsp_data_d  = dsp_data_q;
    mcr_d       = mcr_q;
`ifdef LC3_KB_IRQ_EN
    kbie_d      = kbie_q;
`endif
    ready       = 1'b0;
    sram_cs     = 1'b0;
    sram_we     = 1'b0;
    kbdr_clr    = 1'b0;
    dsp_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mio_en) begin
          rw_d    = r_w;
          mar_d   = mar;
          wdata_d = mdr_in;
          if (mar < IO_BASE) begin
            state_d = SRAM;
          end else begin
            state_d = RESP;
            if (!r_w) begin
              rdata_d = reg_val;
              if (mar == KBDR_A) kbdr_clr = 1'b1;
            end else begin
              if (mar == MCR_A) mcr_d = mdr_in;
              if (mar == DDR_A && !dsp_valid_q) dsp_load = 1'b1;
`ifdef LC3_KB_IRQ_EN
              if (mar == KBSR_A) kbie_d = mdr_in[14];
`endif
            end
          end
        end
      end
      SRAM: begin
        sram_cs = 1'b1;
        sram_we = rw_q;
        cnt_d   = LAT_M1;
        state_d = (LAT_M1 == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        ready = 1'b1;
        if (!rw_q && mar_q < IO_BASE) rdata_d = sram_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A KBDR read clear takes priority over an incoming character.
    if (kbdr_clr) begin
      kbsr15_d = 1'b0;
    end else if (kb_valid && !kbsr15_q) begin
      kbdr_d   = kb_data;
      kbsr15_d = 1'b1;
    end

    // Display: consume on handshake; a load only happens when nothing is pending.
    if (dsp_valid_q && dsp_ready) dsp_valid_d = 1'b0;
    if (dsp_load) begin
      dsp_valid_d = 1'b1;
      dsp_data_d  = mdr_in[7:0];
    end
  end

`ifdef LC3_KB_IRQ_EN
  assign kb_irq_d = kbsr15_d & kbie_d;
`endif

  // State and register flops; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      mar_q       <= 16'h0000;
      wdata_q     <= 16'h0000;
      cnt_q       <= 4'd0;
      rdata_q     <= 16'h0000;
      kbsr15_q    <= 1'b0;
      kbdr_q      <= 8'h00;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= 8'h00;
      mcr_q       <= 16'h8000;
`ifdef LC3_KB_IRQ_EN
      kbie_q      <= 1'b0;
      kb_irq_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      mar_q       <= mar_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      kbsr15_q    <= kbsr15_d;
      kbdr_q      <= kbdr_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
      mcr_q       <= mcr_d;
`ifdef LC3_KB_IRQ_EN
      kbie_q      <= kbie_d;
      kb_irq_q    <= kb_irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_lc3_mem_resp.sv
// tb_lc3_mem_resp: directed bench for lc3_mem_resp (MEM_LAT=2).
// Table of bus transactions plus hand sequences for keyboard, display,
// MCR and reset-during-wait behaviour.
module tb_lc3_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mio_en = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] mar = 16'h0;
  logic [15:0] mdr_in = 16'h0;
  logic        psr_15 = 1'b0;
  logic [15:0] mem_rdata;
  logic        ready;
  logic        acv;
  logic        sram_cs;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = 16'h0;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h0;
  logic        kb_ready;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready = 1'b0;
  logic        halt;
  logic [1:0]  dbg_state;
`ifdef LC3_KB_IRQ_EN
  logic        kb_irq;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  lc3_mem_resp #(.MEM_LAT(2), .USR_LO(16'h3000), .IO_BASE(16'hFE00)) dut (
    .clk(clk), .rst_n(rst_n), .mio_en(mio_en), .r_w(r_w), .mar(mar),
    .mdr_in(mdr_in), .psr_15(psr_15), .mem_rdata(mem_rdata), .ready(ready),
    .acv(acv), .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .kb_valid(kb_valid),
    .kb_data(kb_data), .kb_ready(kb_ready), .dsp_valid(dsp_valid),
    .dsp_data(dsp_data), .dsp_ready(dsp_ready), .halt(halt),
`ifdef LC3_KB_IRQ_EN
    .kb_irq(kb_irq),
`endif
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous SRAM model: read data appears the cycle after sram_cs and is held.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        psr;
    logic [15:0] exp_rdata;
    int          exp_lat;
    logic        exp_acv;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction: drive, hold mio_en until ready, report data and latency.
  task automatic do_req(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                        output logic [15:0] rd, output int lat);
    r_w    = rw;
    mar    = addr;
    mdr_in = data;
    mio_en = 1'b1;
    lat    = -1;
    rd     = 16'hxxxx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        chk("sram_cs_c1", sram_cs, (addr < 16'hFE00) ? 1'b1 : 1'b0);
        if (addr < 16'hFE00) begin
          chk("sram_we_c1", sram_we, rw);
          chk("sram_addr_c1", sram_addr, addr);
          if (rw) chk("sram_wdata_c1", sram_wdata, data);
        end
      end
      if (c == 2 && addr < 16'hFE00) chk("sram_cs_pulse", sram_cs, 1'b0);
      if (ready) begin
        lat = c;
        rd  = mem_rdata;
        break;
      end
    end
    mio_en = 1'b0;
    if (lat < 0) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] rd;
    int          lat;
    do_req(1'b0, addr, 16'h0, rd, lat);
    chk(name, rd, exp);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] rd;
    int          lat;
    do_req(1'b1, addr, data, rd, lat);
  endtask

  task automatic key(input logic [7:0] ch);
    kb_data  = ch;
    kb_valid = 1'b1;
    tick();
    kb_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int          lat;

    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

    //                rw    addr      wdata     psr   rdata     lat acv
    vecs[0]  = '{1'b1, 16'h3000, 16'h1234, 1'b0, 16'h0000, 3, 1'b0};
    vecs[1]  = '{1'b0, 16'h3000, 16'h0000, 1'b0, 16'h1234, 3, 1'b0};
    vecs[2]  = '{1'b1, 16'h2FFF, 16'hABCD, 1'b1, 16'h1234, 3, 1'b1};
    vecs[3]  = '{1'b0, 16'h2FFF, 16'h0000, 1'b1, 16'hABCD, 3, 1'b1};
    vecs[4]  = '{1'b1, 16'hFDFF, 16'h0F0F, 1'b0, 16'hABCD, 3, 1'b0};
    vecs[5]  = '{1'b0, 16'hFDFF, 16'h0000, 1'b1, 16'h0F0F, 3, 1'b0};
    vecs[6]  = '{1'b0, 16'hFE00, 16'h0000, 1'b1, 16'h0000, 1, 1'b1};
    vecs[7]  = '{1'b0, 16'hFFFE, 16'h0000, 1'b0, 16'h8000, 1, 1'b0};
    vecs[8]  = '{1'b0, 16'hFE04, 16'h0000, 1'b0, 16'h8000, 1, 1'b0};
    vecs[9]  = '{1'b1, 16'hFE10, 16'h5555, 1'b0, 16'h8000, 1, 1'b0};
    vecs[10] = '{1'b0, 16'hFE10, 16'h0000, 1'b1, 16'h0000, 1, 1'b1};
    vecs[11] = '{1'b0, 16'h3000, 16'h0000, 1'b1, 16'h1234, 3, 1'b0};
    vecs[12] = '{1'b0, 16'h2FFF, 16'h0000, 1'b0, 16'hABCD, 3, 1'b0};
    vecs[13] = '{1'b0, 16'hFE08, 16'h0000, 1'b1, 16'h0000, 1, 1'b1};

    // Reset block
    tick();
    tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 16'h0000);
    chk("rst_sram_cs", sram_cs, 1'b0);
    chk("rst_sram_we", sram_we, 1'b0);
    chk("rst_dsp_valid", dsp_valid, 1'b0);
    chk("rst_dsp_data", dsp_data, 8'h00);
    chk("rst_halt", halt, 1'b0);
    chk("rst_kb_ready", kb_ready, 1'b1);
    chk("rst_state", dbg_state, 2'd0);
`ifdef LC3_KB_IRQ_EN
    chk("rst_kb_irq", kb_irq, 1'b0);
`endif
    rst_n = 1'b1;
    tick();

    // Table-driven transactions
    for (int i = 0; i < 14; i++) begin
      psr_15 = vecs[i].psr;
      mar    = vecs[i].addr;
      #1;
      chk($sformatf("acv_v%0d", i), acv, vecs[i].exp_acv);
      do_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("lat_v%0d", i), lat, vecs[i].exp_lat);
      chk($sformatf("rdata_v%0d", i), rd, vecs[i].exp_rdata);
      tick();
      chk($sformatf("ready_pulse_v%0d", i), ready, 1'b0);
    end
    psr_15 = 1'b0;

    // Keyboard: accept, status, read-clear, next character
    key(8'h41);
    chk("kb_ready_full", kb_ready, 1'b0);
    rd_chk("kbsr_full", 16'hFE00, 16'h8000);
    rd_chk("kbdr_41", 16'hFE02, 16'h0041);
    chk("kb_ready_after_rd", kb_ready, 1'b1);
    tick();
    key(8'h42);
    chk("kb_ready_42", kb_ready, 1'b0);
    // Character held on the bus during the KBDR read is taken only after the clear.
    kb_data  = 8'h43;
    kb_valid = 1'b1;
    rd_chk("kbdr_42", 16'hFE02, 16'h0042);
    chk("kb_ready_resp", kb_ready, 1'b1);
    tick();
    kb_valid = 1'b0;
    chk("kb_ready_43", kb_ready, 1'b0);
    rd_chk("kbdr_43", 16'hFE02, 16'h0043);
    tick();

    // Interrupt enable bit
    wr(16'hFE00, 16'h4000);
    tick();
`ifdef LC3_KB_IRQ_EN
    rd_chk("kbsr_ie", 16'hFE00, 16'h4000);
    chk("kb_irq_idle", kb_irq, 1'b0);
    key(8'h44);
    chk("kb_irq_set", kb_irq, 1'b1);
    rd_chk("kbsr_ie_full", 16'hFE00, 16'hC000);
    rd_chk("kbdr_44", 16'hFE02, 16'h0044);
    chk("kb_irq_clr", kb_irq, 1'b0);
`else
    rd_chk("kbsr_no_ie", 16'hFE00, 16'h0000);
    key(8'h44);
    rd_chk("kbsr_no_ie_full", 16'hFE00, 16'h8000);
    rd_chk("kbdr_44", 16'hFE02, 16'h0044);
`endif
    tick();

    // Display
    dsp_ready = 1'b0;
    wr(16'hFE06, 16'h0058);
    chk("dsp_valid_set", dsp_valid, 1'b1);
    chk("dsp_data_58", dsp_data, 8'h58);
    tick();
    rd_chk("dsr_busy", 16'hFE04, 16'h0000);
    tick();
    wr(16'hFE06, 16'h0059);
    tick();
    chk("dsp_drop", dsp_data, 8'h58);
    chk("dsp_valid_hold", dsp_valid, 1'b1);
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    chk("dsp_valid_clr", dsp_valid, 1'b0);
    rd_chk("dsr_idle", 16'hFE04, 16'h8000);
    tick();

    // MCR write halts the machine
    wr(16'hFFFE, 16'h0000);
    chk("halt_set", halt, 1'b1);
    tick();
    rd_chk("mcr_0", 16'hFFFE, 16'h0000);
    tick();

    // Reset while in WAIT aborts the access and drops the pending display character
    wr(16'hFE06, 16'h0061);
    chk("dsp_pending", dsp_valid, 1'b1);
    tick();
    r_w    = 1'b0;
    mar    = 16'h3000;
    mio_en = 1'b1;
    tick();
    tick();
    chk("in_wait", dbg_state, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_abort_state", dbg_state, 2'd0);
    chk("rst_abort_ready", ready, 1'b0);
    mio_en = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_ready_after_rst", ready, 1'b0);
    end
    chk("halt_after_rst", halt, 1'b0);
    chk("dsp_after_rst", dsp_valid, 1'b0);
    chk("mem_rdata_after_rst", mem_rdata, 16'h0000);
    rd_chk("mcr_after_rst", 16'hFFFE, 16'h8000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
